complemento_a_2: RTL and testbench

COMPLEMENTO_A_2 -- requirements
Module: complemento_a_2

---
 rtl/complemento_a_2_pkg.sv | 26 ++
 rtl/complemento_a_2_twos_neg.sv | 46 ++++
 rtl/complemento_a_2.sv | 54 +++++
 tb/tb_complemento_a_2.sv | 137 +++++++++++++
 4 files changed

// File: rtl/complemento_a_2_pkg.sv
// -----------------------------------------------------------------------------
// complemento_a_2_pkg
// Shared constants and helpers for the two's-complement negator.
//   DEFAULT_WIDTH : default operand width
//   MAX_WIDTH     : widest operand supported (helper return width)
//   most_neg(w)   : most-negative w-bit value (1 followed by w-1 zeros)
//   most_pos(w)   : most-positive w-bit value (0 followed by w-1 ones)
// Helpers return MAX_WIDTH bits; callers keep the low w bits.
// -----------------------------------------------------------------------------
package complemento_a_2_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  localparam logic [MAX_WIDTH-1:0] ONE_FULL = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [MAX_WIDTH-1:0] most_neg(input int w);
    return ONE_FULL << (w - 1);
  endfunction

  // Everything below the sign bit set: one less than the most-negative pattern.
  function automatic logic [MAX_WIDTH-1:0] most_pos(input int w);
    return most_neg(w) - ONE_FULL;
  endfunction

endpackage : complemento_a_2_pkg

// File: rtl/complemento_a_2_twos_neg.sv
// -----------------------------------------------------------------------------
// twos_neg
// Purely combinational two's-complement negator.
//   a_i   [WIDTH] : operand, signed two's complement
//   neg_o [WIDTH] : (~a_i + 1) mod 2^WIDTH, or saturated value on overflow
//   ovf_o         : 1 when a_i is the most-negative value
// Build option: define COMPLEMENTO_A_2_SAT_EN to saturate -MIN to MAX
// instead of wrapping back to MIN.
// -----------------------------------------------------------------------------
module twos_neg
  import complemento_a_2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH-1:0] neg_o,
  output logic             ovf_o
);

  localparam logic [MAX_WIDTH-1:0] MOST_NEG_FULL = most_neg(WIDTH);
  localparam logic [WIDTH-1:0]     MOST_NEG      = MOST_NEG_FULL[WIDTH-1:0];
`ifdef COMPLEMENTO_A_2_SAT_EN
  localparam logic [MAX_WIDTH-1:0] MOST_POS_FULL = most_pos(WIDTH);
  localparam logic [WIDTH-1:0]     MOST_POS      = MOST_POS_FULL[WIDTH-1:0];
`endif
  localparam logic [WIDTH-1:0]     ONE           = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] neg_raw;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    neg_raw = ~a_i + ONE;
    ovf_o   = (a_i == MOST_NEG);
    neg_o   = neg_raw;
`ifdef COMPLEMENTO_A_2_SAT_EN
    // -MIN is not representable; clamp to MAX instead of wrapping to MIN.
    if (ovf_o) begin
      neg_o = MOST_POS;
    end
`else
    // Wrap: the raw NOT+1 of MIN is MIN itself, so neg_raw already holds it.
`endif
  end

endmodule : twos_neg

// File: rtl/complemento_a_2.sv
// -----------------------------------------------------------------------------
// complemento_a_2
// Registered two's-complement negation of BTN, one clock of latency.
//   clk          : sole clock, rising edge
//   rst          : synchronous, active-high reset
//   BTN   [WIDTH]: operand A, signed two's complement
//   RESULT[WIDTH]: registered -A
//   LED          : registered overflow flag (A was the most-negative value)
//   ZERO         : RESULT is all zeros (decoded from the registered RESULT)
// Build option: COMPLEMENTO_A_2_SAT_EN selects saturation on overflow
// (handled inside twos_neg).
// -----------------------------------------------------------------------------
module complemento_a_2
  import complemento_a_2_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] BTN,
  output logic [WIDTH-1:0] RESULT,
  output logic             LED,
  output logic             ZERO
);

  logic [WIDTH-1:0] result_d, result_q;
  logic             led_d, led_q;

  twos_neg #(
    .WIDTH (WIDTH)
  ) u_twos_neg (
    .a_i   (BTN),
    .neg_o (result_d),
    .ovf_o (led_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      result_q <= '0;
      led_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      led_q    <= led_d;
    end
  end

  // Decoded from the stored value, so it is 1 during reset with no extra flop.
  assign ZERO   = ~|result_q;
  assign RESULT = result_q;
  assign LED    = led_q;

endmodule : complemento_a_2

// File: tb/tb_complemento_a_2.sv
// -----------------------------------------------------------------------------
// tb_complemento_a_2
// Directed plus randomized bench for complemento_a_2 at WIDTH = 4. Expected
// values come from signed integer negation of the applied operand.
// -----------------------------------------------------------------------------
module tb_complemento_a_2;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] BTN = '0;
  logic [W-1:0] RESULT;
  logic         LED;
  logic         ZERO;

  int vectors     = 0;
  int miscompares = 0;

  complemento_a_2 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .BTN    (BTN),
    .RESULT (RESULT),
    .LED    (LED),
    .ZERO   (ZERO)
  );

  always #5 clk = ~clk;

  // Reference: negate A as a signed integer; if -A exceeds the positive range
  // it is an overflow, then either clamp or reduce modulo 2^W.
  task automatic model(input logic [W-1:0] a, input logic r,
                       output logic [W-1:0] exp_res, output logic exp_led);
    int v;
    int n;
    int m;
    if (r) begin
      exp_res = '0;
      exp_led = 1'b0;
    end else begin
      v = int'(a);
      if (v >= (1 << (W - 1))) v = v - (1 << W);
      n = -v;
      exp_led = (n > (1 << (W - 1)) - 1);
`ifdef COMPLEMENTO_A_2_SAT_EN
      if (exp_led) n = (1 << (W - 1)) - 1;
`endif
      m = ((n % (1 << W)) + (1 << W)) % (1 << W);
      exp_res = m[W-1:0];
    end
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [W-1:0] exp_res,
                               input logic exp_led);
    check({tag, ".RESULT"}, int'(RESULT), int'(exp_res));
    check({tag, ".LED"},    int'(LED),    int'(exp_led));
    check({tag, ".ZERO"},   int'(ZERO),   int'(exp_res == '0));
  endtask

  // Drive on the falling edge, let one rising edge pass, sample 1 ns later.
  task automatic step(input string tag, input logic [W-1:0] a, input logic r);
    logic [W-1:0] exp_res;
    logic         exp_led;
    @(negedge clk);
    BTN = a;
    rst = r;
    @(posedge clk);
    #1;
    model(a, r, exp_res, exp_led);
    check_outputs(tag, exp_res, exp_led);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] hold_res;
    logic         hold_led;
    int           rst_at;

    // Reset held for two edges with a nonzero operand present.
    step("reset0", 4'b0101, 1'b1);
    step("reset1", 4'b0101, 1'b1);

    // First edge after release registers the operand present at that edge.
    step("first_after_reset", 4'b0011, 1'b0);

    // Exhaustive sweep, one value per clock.
    for (int i = 0; i < (1 << W); i++) begin
      a = i[W-1:0];
      step($sformatf("sweep_%0d", i), a, 1'b0);
    end

    step("zero",     4'b0000, 1'b0);
    step("overflow", 4'b1000, 1'b0);
    step("ex_0011",  4'b0011, 1'b0);
    step("ex_0001",  4'b0001, 1'b0);
    step("ex_0111",  4'b0111, 1'b0);

    // Operand changes between edges must not reach the outputs.
    model(4'b0111, 1'b0, hold_res, hold_led);
    BTN = 4'b1000;
    #2;
    BTN = 4'b0000;
    #1;
    check_outputs("hold_between_edges", hold_res, hold_led);

    // Random stream with a reset pulse at a random point, then resumption.
    rst_at = int'($urandom_range(10, 30));
    for (int i = 0; i < 48; i++) begin
      a = 4'($urandom);
      if (i == rst_at || i == rst_at + 1) begin
        step($sformatf("rand_rst_%0d", i), a, 1'b1);
      end else begin
        step($sformatf("rand_%0d", i), a, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net: the stimulus is bounded, but never let a stuck run hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_complemento_a_2
